// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller: bus widths,
// AHB-Lite encodings, controller state encodings and ITCM defaults.
package instr_mem_ctrl_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [31:0] ITCM_BASE_DEFAULT      = 32'h0000_0000;
    localparam int          ITCM_SIZE_LOG2_DEFAULT = 14;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_INSTR   = 4'b0010;

    typedef enum logic [1:0] {
        IMC_IDLE     = 2'd0,
        IMC_AHB_ADDR = 2'd1,
        IMC_AHB_DATA = 2'd2
    } imc_state_t;

    // Clear the byte offset so every fetch is a whole-word access.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instr_mem_ctrl_ahb_rd_master.sv
// Single-transfer AHB-Lite read master. A start pulse captures an address,
// the address phase waits out any previous stretched transfer, and the data
// phase completes on HREADY. A new start may be issued in the completion
// cycle so back-to-back bus fetches need no idle cycle between them.
module ahb_rd_master
    import instr_mem_ctrl_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        start,
    input  logic [31:0] addr,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    imc_state_t  state;
    logic [31:0] addr_r;
    logic [1:0]  htrans_r;

    // Address/data phase sequencing with registered HADDR and HTRANS.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state    <= IMC_IDLE;
            addr_r   <= '0;
            htrans_r <= HTRANS_IDLE;
        end else begin
            case (state)
                IMC_IDLE: begin
                    if (start) begin
                        state    <= IMC_AHB_ADDR;
                        addr_r   <= addr;
                        htrans_r <= HTRANS_NONSEQ;
                    end
                end
                IMC_AHB_ADDR: begin
                    if (HREADY) begin
                        state    <= IMC_AHB_DATA;
                        htrans_r <= HTRANS_IDLE;
                    end
                end
                IMC_AHB_DATA: begin
                    if (HREADY) begin
                        if (start) begin
                            state    <= IMC_AHB_ADDR;
                            addr_r   <= addr;
                            htrans_r <= HTRANS_NONSEQ;
                        end else begin
                            state    <= IMC_IDLE;
                            htrans_r <= HTRANS_IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IMC_IDLE;
                    htrans_r <= HTRANS_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != IMC_IDLE);
    assign done   = (state == IMC_AHB_DATA) && HREADY;
    assign rdata  = HRDATA;
    assign err    = HRESP;

    assign HADDR  = addr_r;
    assign HTRANS = htrans_r;
    assign HWRITE = 1'b0;
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_INSTR;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction-memory responder for the fetch stage. Fetches inside the ITCM
// window stream at one per cycle from the synchronous ITCM; everything else
// becomes a single AHB-Lite read. Every accept cycle issues a request, so a
// stalled fetch holding its pc simply refetches.
module instr_mem_ctrl
    import instr_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] ITCM_BASE      = ITCM_BASE_DEFAULT,
    parameter int          ITCM_SIZE_LOG2 = ITCM_SIZE_LOG2_DEFAULT
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_rstn,
    input  logic [ADDR_WIDTH-1:0]     next_pc,
    output logic                      instr_read_data_valid,
    output logic [INSTR_WIDTH-1:0]    instr_read_data,
    output logic [ADDR_WIDTH-1:0]     instr_read_addr,
    output logic                      addr_AHB,
    output logic                      instr_access_fault,
    output logic                      itcm_cs,
    output logic [ITCM_SIZE_LOG2-3:0] itcm_addr,
    input  logic [31:0]               itcm_rdata,
    output logic [31:0]               HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    input  logic                      HREADY,
    input  logic [31:0]               HRDATA,
    input  logic                      HRESP
);

    logic        hit;
    logic        accept;
    logic        itcm_req;
    logic        ahb_start;
    logic        ahb_busy;
    logic        ahb_done;
    logic [31:0] ahb_rdata;
    logic        ahb_err;
    logic        itcm_pend;
    logic [31:0] pend_addr;

    assign hit       = (next_pc[31:ITCM_SIZE_LOG2] == ITCM_BASE[31:ITCM_SIZE_LOG2]);
    assign accept    = !ahb_busy || ahb_done;
    assign itcm_req  = accept && hit;
    assign ahb_start = accept && !hit;

    assign itcm_cs   = itcm_req;
    assign itcm_addr = next_pc[ITCM_SIZE_LOG2-1:2];

    ahb_rd_master u_ahb_rd_master (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .start    (ahb_start),
        .addr     (word_align(next_pc)),
        .busy     (ahb_busy),
        .done     (ahb_done),
        .rdata    (ahb_rdata),
        .err      (ahb_err),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HRESP    (HRESP)
    );

    // ITCM pipeline stage and the sticky bus-source flag, updated per accept.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            itcm_pend <= 1'b0;
            pend_addr <= '0;
            addr_AHB  <= 1'b0;
        end else begin
            itcm_pend <= itcm_req;
            if (itcm_req) begin
                pend_addr <= word_align(next_pc);
            end
            if (accept) begin
                addr_AHB <= !hit;
            end
        end
    end

    // Response mux: ITCM data one cycle after the request, AHB data in the
    // completion cycle, and zero data on a bus error.
    always_comb begin
        instr_read_data_valid = itcm_pend || ahb_done;
        instr_access_fault    = ahb_done && ahb_err;
        instr_read_data       = '0;
        if (itcm_pend) begin
            instr_read_data = itcm_rdata;
        end else if (ahb_done && !ahb_err) begin
            instr_read_data = ahb_rdata;
        end
        instr_read_addr = ahb_busy ? HADDR : pend_addr;
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: ITCM streaming, AHB waits, AHB error,
// mixed ITCM/AHB sequencing, window boundary and asynchronous reset.
module tb_instr_mem_ctrl;

    localparam logic [31:0] MEM_PATTERN = 32'hC0DE_0000;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic [31:0] next_pc;
    logic        instr_read_data_valid;
    logic [31:0] instr_read_data;
    logic [31:0] instr_read_addr;
    logic        addr_AHB;
    logic        instr_access_fault;
    logic        itcm_cs;
    logic [11:0] itcm_addr;
    logic [31:0] itcm_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    logic [31:0] itcm_mem [0:4095];

    int errors = 0;
    int checks = 0;

    instr_mem_ctrl #(
        .ITCM_BASE      (32'h0000_0000),
        .ITCM_SIZE_LOG2 (14)
    ) dut (
        .cpu_clk               (cpu_clk),
        .cpu_rstn              (cpu_rstn),
        .next_pc               (next_pc),
        .instr_read_data_valid (instr_read_data_valid),
        .instr_read_data       (instr_read_data),
        .instr_read_addr       (instr_read_addr),
        .addr_AHB              (addr_AHB),
        .instr_access_fault    (instr_access_fault),
        .itcm_cs               (itcm_cs),
        .itcm_addr             (itcm_addr),
        .itcm_rdata            (itcm_rdata),
        .HADDR                 (HADDR),
        .HTRANS                (HTRANS),
        .HWRITE                (HWRITE),
        .HSIZE                 (HSIZE),
        .HBURST                (HBURST),
        .HPROT                 (HPROT),
        .HREADY                (HREADY),
        .HRDATA                (HRDATA),
        .HRESP                 (HRESP)
    );

    // Free-running clock.
    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    // Synchronous single-port ITCM model: word i holds MEM_PATTERN | i.
    initial begin
        for (int i = 0; i < 4096; i++) begin
            itcm_mem[i] = MEM_PATTERN | i;
        end
    end

    // ITCM read port: data appears the cycle after the chip select.
    always @(posedge cpu_clk) begin
        if (itcm_cs) begin
            itcm_rdata <= itcm_mem[itcm_addr];
        end
    end

    // Move to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_rstn = 1'b0;
        next_pc  = 32'h0;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        HRDATA   = 32'h0;
        repeat (2) @(posedge cpu_clk);
        #2;
        checks++;
        if (instr_read_data_valid !== 1'b0 || instr_access_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got valid=%b fault=%b expected 0 0", instr_read_data_valid, instr_access_fault);
        end
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_ahb: got HTRANS=%b HADDR=%h expected 00 00000000", HTRANS, HADDR);
        end
        checks++;
        if (addr_AHB !== 1'b0 || instr_read_addr !== 32'h0 || instr_read_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got addr_AHB=%b raddr=%h rdata=%h expected 0 0 0", addr_AHB, instr_read_addr, instr_read_data);
        end
        cpu_rstn = 1'b1;
        #1;
        checks++;
        if (itcm_cs !== 1'b1 || itcm_addr !== 12'h000) begin
            errors++;
            $display("[TB] FAIL first_req: got cs=%b addr=%h expected 1 000", itcm_cs, itcm_addr);
        end
        tick();
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hC0DE_0000 || instr_read_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL first_resp: got v=%b d=%h a=%h expected 1 c0de0000 00000000", instr_read_data_valid, instr_read_data, instr_read_addr);
        end
    endtask

    task automatic test_itcm_stream();
        logic [31:0] exp_data;
        for (int k = 0; k < 5; k++) begin
            tick();
            next_pc = (k < 4) ? 32'(4 * k) : 32'h10;
            #1;
            if (k > 0) begin
                exp_data = MEM_PATTERN | 32'(k - 1);
                checks++;
                if (instr_read_data_valid !== 1'b1 || instr_read_data !== exp_data || addr_AHB !== 1'b0
                    || instr_read_addr !== 32'(4 * (k - 1))) begin
                    errors++;
                    $display("[TB] FAIL stream_%0d: got v=%b d=%h ahb=%b a=%h expected 1 %h 0 %h", k,
                             instr_read_data_valid, instr_read_data, addr_AHB, instr_read_addr, exp_data, 32'(4 * (k - 1)));
                end
            end
        end
    endtask

    task automatic test_ahb_wait();
        tick();
        next_pc = 32'h2000_0010;
        #1;
        checks++;
        if (itcm_cs !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_accept_cs: got %b expected 0", itcm_cs);
        end
        tick();
        HREADY = 1'b1;
        #1;
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h2000_0010 || itcm_cs !== 1'b0 || instr_read_data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_addr_phase: got HTRANS=%b HADDR=%h cs=%b v=%b expected 10 20000010 0 0",
                     HTRANS, HADDR, itcm_cs, instr_read_data_valid);
        end
        checks++;
        if ({HWRITE, HSIZE, HBURST, HPROT} !== {1'b0, 3'b010, 3'b000, 4'b0010} || addr_AHB !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_ctrl: got W=%b S=%b B=%b P=%b ahb=%b expected 0 010 000 0010 1",
                     HWRITE, HSIZE, HBURST, HPROT, addr_AHB);
        end
        for (int w = 0; w < 2; w++) begin
            tick();
            HREADY = 1'b0;
            #1;
            checks++;
            if (HTRANS !== 2'b00 || instr_read_data_valid !== 1'b0 || itcm_cs !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wait_state_%0d: got HTRANS=%b v=%b cs=%b expected 00 0 0", w, HTRANS, instr_read_data_valid, itcm_cs);
            end
        end
        tick();
        HREADY = 1'b1;
        HRDATA = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hDEAD_BEEF || addr_AHB !== 1'b1
            || instr_access_fault !== 1'b0 || itcm_cs !== 1'b0 || instr_read_addr !== 32'h2000_0010) begin
            errors++;
            $display("[TB] FAIL wait_done: got v=%b d=%h ahb=%b f=%b cs=%b a=%h expected 1 deadbeef 1 0 0 20000010",
                     instr_read_data_valid, instr_read_data, addr_AHB, instr_access_fault, itcm_cs, instr_read_addr);
        end
        tick();
        next_pc = 32'h0000_0020;
        #1;
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h2000_0010 || instr_read_data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL refetch_addr: got HTRANS=%b HADDR=%h v=%b expected 10 20000010 0", HTRANS, HADDR, instr_read_data_valid);
        end
        tick();
        HRDATA = 32'h1234_5678;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'h1234_5678 || itcm_cs !== 1'b1 || itcm_addr !== 12'h008) begin
            errors++;
            $display("[TB] FAIL switch_done: got v=%b d=%h cs=%b ia=%h expected 1 12345678 1 008",
                     instr_read_data_valid, instr_read_data, itcm_cs, itcm_addr);
        end
        tick();
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hC0DE_0008 || addr_AHB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL switch_itcm: got v=%b d=%h ahb=%b expected 1 c0de0008 0", instr_read_data_valid, instr_read_data, addr_AHB);
        end
    endtask

    task automatic test_ahb_error();
        tick();
        next_pc = 32'h3000_0000;
        tick();
        HREADY = 1'b1;
        tick();
        HREADY = 1'b0;
        HRESP  = 1'b1;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b0 || instr_access_fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_cycle1: got v=%b f=%b expected 0 0", instr_read_data_valid, instr_access_fault);
        end
        tick();
        HREADY  = 1'b1;
        HRDATA  = 32'hFFFF_FFFF;
        next_pc = 32'h0000_0004;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_access_fault !== 1'b1 || instr_read_data !== 32'h0 || itcm_cs !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_cycle2: got v=%b f=%b d=%h cs=%b expected 1 1 00000000 1",
                     instr_read_data_valid, instr_access_fault, instr_read_data, itcm_cs);
        end
        tick();
        HRESP = 1'b0;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_access_fault !== 1'b0 || instr_read_data !== 32'hC0DE_0001) begin
            errors++;
            $display("[TB] FAIL err_recover: got v=%b f=%b d=%h expected 1 0 c0de0001", instr_read_data_valid, instr_access_fault, instr_read_data);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        next_pc = 32'h0000_0008;
        tick();
        next_pc = 32'h2000_0000;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hC0DE_0002 || addr_AHB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mix_n1: got v=%b d=%h ahb=%b expected 1 c0de0002 0", instr_read_data_valid, instr_read_data, addr_AHB);
        end
        tick();
        HREADY = 1'b1;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mix_n2: got v=%b expected 0", instr_read_data_valid);
        end
        tick();
        HRDATA  = 32'hA5A5_0003;
        next_pc = 32'h0000_000C;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hA5A5_0003 || addr_AHB !== 1'b1 || instr_read_addr !== 32'h2000_0000) begin
            errors++;
            $display("[TB] FAIL mix_n3: got v=%b d=%h ahb=%b a=%h expected 1 a5a50003 1 20000000",
                     instr_read_data_valid, instr_read_data, addr_AHB, instr_read_addr);
        end
        tick();
        next_pc = 32'h0000_0010;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hC0DE_0003 || addr_AHB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mix_n4: got v=%b d=%h ahb=%b expected 1 c0de0003 0", instr_read_data_valid, instr_read_data, addr_AHB);
        end
    endtask

    task automatic test_boundary();
        tick();
        next_pc = 32'h0000_3FFE;
        #1;
        checks++;
        if (itcm_cs !== 1'b1 || itcm_addr !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL edge_last_req: got cs=%b ia=%h expected 1 fff", itcm_cs, itcm_addr);
        end
        tick();
        next_pc = 32'h0000_4000;
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hC0DE_0FFF || instr_read_addr !== 32'h0000_3FFC || itcm_cs !== 1'b0) begin
            errors++;
            $display("[TB] FAIL edge_last_resp: got v=%b d=%h a=%h cs=%b expected 1 c0de0fff 00003ffc 0",
                     instr_read_data_valid, instr_read_data, instr_read_addr, itcm_cs);
        end
        tick();
        next_pc = 32'h0000_0000;
        #1;
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h0000_4000) begin
            errors++;
            $display("[TB] FAIL edge_miss: got HTRANS=%b HADDR=%h expected 10 00004000", HTRANS, HADDR);
        end
        tick();
        HRDATA = 32'h0BAD_F00D;
        tick();
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hC0DE_0000 || addr_AHB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL edge_return: got v=%b d=%h ahb=%b expected 1 c0de0000 0", instr_read_data_valid, instr_read_data, addr_AHB);
        end
    endtask

    task automatic test_reset_mid_ahb();
        tick();
        next_pc = 32'h2000_0100;
        tick();
        HREADY = 1'b1;
        tick();
        HREADY = 1'b0;
        #1;
        checks++;
        if (addr_AHB !== 1'b1 || HADDR !== 32'h2000_0100) begin
            errors++;
            $display("[TB] FAIL rst_pre: got ahb=%b HADDR=%h expected 1 20000100", addr_AHB, HADDR);
        end
        cpu_rstn = 1'b0;
        HREADY   = 1'b1;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || instr_read_data_valid !== 1'b0 || addr_AHB !== 1'b0 || HADDR !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_async: got HTRANS=%b v=%b ahb=%b HADDR=%h expected 00 0 0 00000000",
                     HTRANS, instr_read_data_valid, addr_AHB, HADDR);
        end
        tick();
        cpu_rstn = 1'b1;
        next_pc  = 32'h0000_0014;
        #1;
        checks++;
        if (itcm_cs !== 1'b1 || itcm_addr !== 12'h005) begin
            errors++;
            $display("[TB] FAIL rst_fresh_req: got cs=%b ia=%h expected 1 005", itcm_cs, itcm_addr);
        end
        tick();
        #1;
        checks++;
        if (instr_read_data_valid !== 1'b1 || instr_read_data !== 32'hC0DE_0005 || instr_read_addr !== 32'h0000_0014) begin
            errors++;
            $display("[TB] FAIL rst_fresh_resp: got v=%b d=%h a=%h expected 1 c0de0005 00000014",
                     instr_read_data_valid, instr_read_data, instr_read_addr);
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        test_reset();
        test_itcm_stream();
        test_ahb_wait();
        test_ahb_error();
        test_back_to_back();
        test_boundary();
        test_reset_mid_ahb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Responder side of the fetch ↔ instruction-memory interface. Each accept cycle it samples `next_pc` and returns the 32-bit instruction with `instr_read_data_valid`. Addresses inside the ITCM window are served from a synchronous single-port ITCM at one instruction per cycle. All other addresses go out as single AHB-Lite read transfers, and `addr_AHB` flags them.

## Interface
Parameters:
- `ITCM_BASE`, default 32'h0000_0000: ITCM window base. Must be aligned to the window size.
- `ITCM_SIZE_LOG2`, default 14: ITCM window is 2^14 bytes (16 KB).

Ports:
- `cpu_clk`  in  1  clock.
- `cpu_rstn`  in  1  reset: asynchronous, active-low.
- `next_pc`  in  `ADDR_WIDTH`  fetch address, sampled in accept cycles.
- `instr_read_data_valid`  out  1  response valid; lasts one cycle per access.
- `instr_read_data`  out  `INSTR_WIDTH`  instruction; meaningful only while valid is high.
- `instr_read_addr`  out  `ADDR_WIDTH`  word address of the access being returned.
- `addr_AHB`  out  1  the in-flight or returning access is on AHB.
- `instr_access_fault`  out  1  AHB error response; qualified by valid.
- `itcm_cs`  out  1  ITCM read enable.
- `itcm_addr`  out  `ITCM_SIZE_LOG2-2`  ITCM word index, `next_pc[ITCM_SIZE_LOG2-1:2]`.
- `itcm_rdata`  in  32  ITCM read data, available the cycle after `itcm_cs`.
- `HADDR` out 32, `HTRANS` out 2, `HWRITE` out 1, `HSIZE` out 3, `HBURST` out 3, `HPROT` out 4: AHB-Lite master outputs.
- `HREADY` in 1, `HRDATA` in 32, `HRESP` in 1: AHB-Lite master inputs.

## Operation
- `hit = next_pc[31:ITCM_SIZE_LOG2] == ITCM_BASE[31:ITCM_SIZE_LOG2]`.
- Addresses are word-aligned internally: `{next_pc[31:2],2'b00}`. Misalignment is flagged by fetch, not here.
- States:
  - IDLE: ITCM streaming.
  - AHB_ADDR: address phase.
  - AHB_DATA: data phase.
- `ahb_done = (state==AHB_DATA) && HREADY`.
- `accept = (state==IDLE) || ahb_done`.
- In an accept cycle with `hit`:
  - drive `itcm_cs=1`;
  - set `itcm_pend` and `pend_addr`;
  - stay in or return to IDLE.
- In an accept cycle with `!hit`:
  - `itcm_cs=0`;
  - capture the address into `ahb_addr_r`;
  - go to AHB_ADDR.
- An accept cycle with no request does not exist: every accept cycle issues a request, even when `next_pc` repeats an address. Fetch holds `next_pc=pc` while stalled, so refetch is intended.
- AHB_ADDR:
  - `HTRANS=NONSEQ` (2'b10), `HADDR=ahb_addr_r`.
  - `HWRITE=0`, `HSIZE=3'b010`, `HBURST=3'b000`, `HPROT=4'b0010`.
  - `HREADY=1` → AHB_DATA; otherwise hold (previous transfer stretching).
- AHB_DATA: `HTRANS=IDLE`. On `HREADY=1` the access completes. No address pipelining.
- ITCM response: `instr_read_data_valid = itcm_pend`, data from `itcm_rdata`.
- AHB response: valid = `ahb_done`, data from `HRDATA`. When `HRESP=1`:
  - `instr_access_fault=1`;
  - data forced to 32'h0000_0000.
- `HTRANS=IDLE` in IDLE and AHB_DATA states.
- `itcm_pend` clears on any accept cycle that is not an ITCM hit.
- `addr_AHB` rules:
  - set when entering AHB_ADDR;
  - held through AHB_DATA, including the completion cycle;
  - cleared on an accept cycle with `hit`.
- Reset values:
  - state IDLE;
  - `itcm_pend=0`, valid 0, fault 0, `addr_AHB=0`;
  - `HTRANS=2'b00`, `HADDR=0`;
  - `instr_read_addr=0`, `instr_read_data=0`.

## Timing
- ITCM: request in cycle N, valid in N+1.
- ITCM throughput: 1 instruction/cycle back-to-back, because N+1 is itself an accept cycle.
- AHB: accept in N; address phase from N+1; first data-phase cycle is N+2 at the earliest.
- AHB valid is combinational in the cycle `HREADY=1` in data phase. Each wait state adds one cycle.
- AHB → ITCM switch: the completion cycle issues `itcm_cs`, and the ITCM instruction returns the next cycle.
- Error: AHB two-cycle error. Cycle 1 is `HREADY=0,HRESP=1` with no valid. Cycle 2 is `HREADY=1,HRESP=1`: valid=1 and fault=1.
- `itcm_cs` is never asserted while state is AHB_ADDR or AHB_DATA.
- Reset asserted mid-AHB transfer: outputs drop to reset values asynchronously and the transfer is abandoned. The slave is reset by the same `cpu_rstn`.
- `next_pc` changing in non-accept cycles is ignored.

## Structure
- Add to `core_defines.vh`:
  - HTRANS encodings `HTRANS_IDLE`, `HTRANS_NONSEQ`;
  - state encodings `IMC_IDLE`, `IMC_AHB_ADDR`, `IMC_AHB_DATA`;
  - default ITCM constants.
- One natural sub-module, `ahb_rd_master`. It owns the AHB_ADDR/AHB_DATA sequencing and takes `start`/`addr`, returning `done`/`rdata`/`err`.
- The region decode and ITCM pipeline stay in the top level.

## Test plan
- Reset release, `next_pc`=0x0, `ITCM_BASE`=0 → cycle 0: `itcm_cs=1`, `itcm_addr=0`; cycle 1: valid=1, data=mem[0], `instr_read_addr`=0.
- `next_pc` 0x0, 0x4, 0x8, 0xC in consecutive cycles → valid on 4 consecutive cycles, data mem[0..3], `addr_AHB=0` throughout.
- `next_pc`=0x2000_0010, slave inserts 2 wait states with HRDATA=0xDEAD_BEEF:
  - N+1: `HTRANS=NONSEQ`, `HADDR`=0x2000_0010;
  - valid at N+4, data 0xDEAD_BEEF, `addr_AHB=1`;
  - no `itcm_cs` during N+1..N+4.
- AHB error on 0x3000_0000 → no valid in the first error cycle; second cycle valid=1, `instr_access_fault=1`, data=0; the next accept proceeds normally.
- Sequence ITCM 0x8 → AHB 0x2000_0000 (0 waits) → ITCM 0xC:
  - valid cycles at N+1, N+3, N+4;
  - `addr_AHB` is 0, 1, 0 respectively.
- `cpu_rstn` asserted during AHB_DATA with `HREADY=0` → same cycle: `HTRANS=00`, valid=0, state IDLE.
- After reset release, a fresh ITCM fetch returns in 1 cycle.
